// File: rtl/kf_fixed_pkg.sv
// Shared fixed-point definitions for the Kalman-filter datapath blocks:
// default word geometry, the word type, the 1.0 constant and the predict-stage FSM states.
package kf_fixed_pkg;

  localparam int FX_N    = 20;
  localparam int FX_FRAC = 10;

  typedef logic signed [FX_N-1:0] fx_t;

  localparam fx_t ONE = fx_t'(1 << FX_FRAC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } prior_state_e;

endpackage

// File: rtl/fx_mul.sv
// Signed N x N fixed-point multiply: full 2N-bit product, arithmetic shift right by FRAC
// (floor), truncated to N bits. Purely combinational.
module fx_mul #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  logic signed [2*N-1:0] a_w;
  logic signed [2*N-1:0] b_w;
  logic signed [2*N-1:0] prod;

  assign a_w  = (2*N)'(a);
  assign b_w  = (2*N)'(b);
  assign prod = a_w * b_w;
  assign p    = N'(prod >>> FRAC);

endmodule

// File: rtl/prior_state_serial.sv
// Kalman predict stage: x_prior = A*x + B*u using one shared multiplier, 8 serial MAC cycles.
// Define PRIOR_STATE_SAT_EN to saturate each row sum instead of wrapping modulo 2^N.
module prior_state_serial
  import kf_fixed_pkg::*;
#(
  parameter int N    = FX_N,
  parameter int FRAC = FX_FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] x00,
  input  logic signed [N-1:0] x10,
  input  logic signed [N-1:0] a00,
  input  logic signed [N-1:0] a01,
  input  logic signed [N-1:0] a10,
  input  logic signed [N-1:0] a11,
  input  logic signed [N-1:0] u00,
  input  logic signed [N-1:0] u10,
  input  logic signed [N-1:0] b00,
  input  logic signed [N-1:0] b01,
  input  logic signed [N-1:0] b10,
  input  logic signed [N-1:0] b11,
  output logic                done,
  output logic signed [N-1:0] X_PRIOR00,
  output logic signed [N-1:0] X_PRIOR10
);

`ifdef PRIOR_STATE_SAT_EN
  localparam int ACC_W = N + 3;
`else
  localparam int ACC_W = N;
`endif

  typedef logic signed [N-1:0]     word_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    word_t a00, a01, a10, a11;
    word_t b00, b01, b10, b11;
    word_t x00, x10, u00, u10;
  } ops_t;

`ifdef PRIOR_STATE_SAT_EN
  localparam acc_t SAT_MAX = acc_t'((2 ** (N - 1)) - 1);
  localparam acc_t SAT_MIN = -acc_t'(2 ** (N - 1));
`endif

  function automatic word_t to_word(input acc_t v);
`ifdef PRIOR_STATE_SAT_EN
    if (v > SAT_MAX)      return word_t'(SAT_MAX);
    else if (v < SAT_MIN) return word_t'(SAT_MIN);
    else                  return word_t'(v);
`else
    return v;
`endif
  endfunction

  prior_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  acc_t         acc_q, acc_d;
  acc_t         row0_q, row0_d;
  ops_t         ops_q, ops_d;
  logic         done_q, done_d;
  word_t        xp0_q, xp0_d;
  word_t        xp1_q, xp1_d;

  word_t mul_coef;
  word_t mul_vec;
  word_t prod;
  acc_t  acc_sum;

  // cnt[2] selects the row; cnt[1:0] walks the A terms then the B terms.
  always_comb begin
    mul_coef = '0;
    mul_vec  = '0;
    case (cnt_q[1:0])
      2'd0: begin
        mul_coef = cnt_q[2] ? ops_q.a10 : ops_q.a00;
        mul_vec  = ops_q.x00;
      end
      2'd1: begin
        mul_coef = cnt_q[2] ? ops_q.a11 : ops_q.a01;
        mul_vec  = ops_q.x10;
      end
      2'd2: begin
        mul_coef = cnt_q[2] ? ops_q.b10 : ops_q.b00;
        mul_vec  = ops_q.u00;
      end
      default: begin
        mul_coef = cnt_q[2] ? ops_q.b11 : ops_q.b01;
        mul_vec  = ops_q.u10;
      end
    endcase
  end

  fx_mul #(.N(N), .FRAC(FRAC)) u_mul (
    .a (mul_coef),
    .b (mul_vec),
    .p (prod)
  );

  assign acc_sum = acc_q + acc_t'(prod);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    row0_d  = row0_q;
    ops_d   = ops_q;
    done_d  = 1'b0;
    xp0_d   = xp0_q;
    xp1_d   = xp1_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ops_d = '{a00: a00, a01: a01, a10: a10, a11: a11,
                    b00: b00, b01: b01, b10: b10, b11: b11,
                    x00: x00, x10: x10, u00: u00, u10: u10};
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          // Row 0 complete: park it and restart the accumulator for row 1.
          row0_d = acc_sum;
          acc_d  = '0;
        end else begin
          acc_d = acc_sum;
        end
        if (cnt_q == 3'd7) state_d = ST_DONE;
      end
      ST_DONE: begin
        xp0_d   = to_word(row0_q);
        xp1_d   = to_word(acc_q);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      row0_q  <= '0;
      done_q  <= 1'b0;
      xp0_q   <= '0;
      xp1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      row0_q  <= row0_d;
      done_q  <= done_d;
      xp0_q   <= xp0_d;
      xp1_q   <= xp1_d;
    end
  end

  // NOTE: the operand latch has no reset; it is always reloaded on an accepted start before use.
  always_ff @(posedge clk) begin
    ops_q <= ops_d;
  end

  assign done      = done_q;
  assign X_PRIOR00 = xp0_q;
  assign X_PRIOR10 = xp1_q;

endmodule

// File: tb/tb_prior_state_serial.sv
// Directed self-checking bench for prior_state_serial: reset, nominal, floor, overflow,
// busy start, mid-run reset and back-to-back starts. Honours PRIOR_STATE_SAT_EN.
module tb_prior_state_serial;
  import kf_fixed_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  fx_t  x00, x10, a00, a01, a10, a11, u00, u10, b00, b01, b10, b11;
  logic done;
  fx_t  xp0, xp1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prior_state_serial dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x00       (x00),
    .x10       (x10),
    .a00       (a00),
    .a01       (a01),
    .a10       (a10),
    .a11       (a11),
    .u00       (u00),
    .u10       (u10),
    .b00       (b00),
    .b01       (b01),
    .b10       (b10),
    .b11       (b11),
    .done      (done),
    .X_PRIOR00 (xp0),
    .X_PRIOR10 (xp1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int va00, input int va01, input int va10, input int va11,
                         input int vb00, input int vb01, input int vb10, input int vb11,
                         input int vx00, input int vx10, input int vu00, input int vu10);
    a00 = fx_t'(va00); a01 = fx_t'(va01); a10 = fx_t'(va10); a11 = fx_t'(va11);
    b00 = fx_t'(vb00); b01 = fx_t'(vb01); b10 = fx_t'(vb10); b11 = fx_t'(vb11);
    x00 = fx_t'(vx00); x10 = fx_t'(vx10); u00 = fx_t'(vu00); u10 = fx_t'(vu10);
  endtask

  task automatic set_nominal();
    set_ops(1024, 1024, 0, 1024, 512, 0, 1024, 0, 1024, -512, 256, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done; -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst   = 1'b1;
    start = 1'b1;
    set_nominal();
    tick();
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++;
    if (xp0 !== fx_t'(0)) begin errors++; $display("FAIL reset_x0: got %0d expected 0", xp0); end
    checks++;
    if (xp1 !== fx_t'(0)) begin errors++; $display("FAIL reset_x1: got %0d expected 0", xp1); end
    rst   = 1'b0;
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_start_ignored: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_nominal();
    int lat;
    set_nominal();
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL nominal_latency: got %0d expected 9", lat); end
    checks++;
    if (xp0 !== fx_t'(640)) begin errors++; $display("FAIL nominal_x0: got %0d expected 640", xp0); end
    checks++;
    if (xp1 !== fx_t'(-256)) begin errors++; $display("FAIL nominal_x1: got %0d expected -256", xp1); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL nominal_done_width: got %0b expected 0", done); end
  endtask

  task automatic test_floor();
    int lat;
    set_ops(512, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL floor_latency: got %0d expected 9", lat); end
    checks++;
    if (xp0 !== fx_t'(-1)) begin errors++; $display("FAIL floor_x0: got %0d expected -1", xp0); end
    checks++;
    if (xp1 !== fx_t'(0)) begin errors++; $display("FAIL floor_x1: got %0d expected 0", xp1); end
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    int exp0;
`ifdef PRIOR_STATE_SAT_EN
    exp0 = 524287;
`else
    exp0 = -524288;
`endif
    set_ops(1024, 0, 0, 0, 1024, 0, 0, 0, 524287, 0, 1, 0);
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL overflow_latency: got %0d expected 9", lat); end
    checks++;
    if (xp0 !== fx_t'(exp0)) begin errors++; $display("FAIL overflow_x0: got %0d expected %0d", xp0, exp0); end
    checks++;
    if (xp1 !== fx_t'(0)) begin errors++; $display("FAIL overflow_x1: got %0d expected 0", xp1); end
    tick();
  endtask

  task automatic test_busy_start();
    int lat;
    int ndone;
    set_nominal();
    pulse_start();
    for (int i = 1; i <= 3; i++) tick();
    set_ops(1024, 0, 0, 0, 1024, 0, 0, 0, 524287, 0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    ndone = 0;
    for (int i = 5; i <= 25; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL busy_latency: got %0d expected 9", lat); end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
    checks++;
    if (xp0 !== fx_t'(640)) begin errors++; $display("FAIL busy_x0: got %0d expected 640", xp0); end
    checks++;
    if (xp1 !== fx_t'(-256)) begin errors++; $display("FAIL busy_x1: got %0d expected -256", xp1); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    set_ops(0, 1024, 1024, 0, 0, 0, 0, 0, 300, 700, 0, 0);
    pulse_start();
    for (int i = 1; i <= 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (xp0 !== fx_t'(0)) begin errors++; $display("FAIL midrst_x0: got %0d expected 0", xp0); end
    checks++;
    if (xp1 !== fx_t'(0)) begin errors++; $display("FAIL midrst_x1: got %0d expected 0", xp1); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", seen); end
    set_ops(0, 1024, 1024, 0, 0, 0, 0, 0, 300, 700, 0, 0);
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL midrst_restart_latency: got %0d expected 9", lat); end
    checks++;
    if (xp0 !== fx_t'(700)) begin errors++; $display("FAIL midrst_restart_x0: got %0d expected 700", xp0); end
    checks++;
    if (xp1 !== fx_t'(300)) begin errors++; $display("FAIL midrst_restart_x1: got %0d expected 300", xp1); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    set_nominal();
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", lat); end
    checks++;
    if (xp0 !== fx_t'(640) || xp1 !== fx_t'(-256)) begin
      errors++;
      $display("FAIL b2b_first_result: got %0d/%0d expected 640/-256", xp0, xp1);
    end
    set_ops(512, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 0);
    pulse_start();
    bad = 0;
    for (int i = 11; i <= 18; i++) begin
      if (done !== 1'b0 || xp0 !== fx_t'(640) || xp1 !== fx_t'(-256)) bad++;
      tick();
    end
    if (done !== 1'b0 || xp0 !== fx_t'(640) || xp1 !== fx_t'(-256)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_hold: got %0d bad cycles expected 0", bad); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %0b expected 1", done); end
    checks++;
    if (xp0 !== fx_t'(-1)) begin errors++; $display("FAIL b2b_second_x0: got %0d expected -1", xp0); end
    checks++;
    if (xp1 !== fx_t'(0)) begin errors++; $display("FAIL b2b_second_x1: got %0d expected 0", xp1); end
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_nominal();
    test_floor();
    test_overflow();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
